// File: rtl/arith_stim_checker.sv
// arith_stim_checker: LFSR operand generator and latency-aligned adder checker with saturating counters
// Ports: clk_dut/reset (sync, active-high); enable issues one operand pair per cycle; freeze holds the
// counter outputs; o_drive_a/o_drive_b feed the adder; i_dut_out is its sum; o_data_ctr/o_event_ctr
// report compared/mismatched samples; o_debug holds the first mismatching sum since reset.
module arith_stim_checker #(
   parameter int          WIDTH   = 32,
   parameter int          LATENCY = 2,
   parameter logic [31:0] SEED_A  = 32'h00000001,
   parameter logic [31:0] SEED_B  = 32'h0000ACE1
) (
   input  logic             clk_dut,
   input  logic             reset,
   input  logic             enable,
   input  logic             freeze,
   output logic [WIDTH-1:0] o_drive_a,
   output logic [WIDTH-1:0] o_drive_b,
   input  logic [WIDTH-1:0] i_dut_out,
   output logic [WIDTH-1:0] o_data_ctr,
   output logic [WIDTH-1:0] o_event_ctr,
   output logic [WIDTH-1:0] o_debug
);
   localparam logic [31:0]      MASK = 32'h80200003;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return {1'b0, x[31:1]} ^ (x[0] ? MASK : 32'h0);
   endfunction

   logic [31:0]      lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
   logic [WIDTH-1:0] drive_a_q, drive_a_d, drive_b_q, drive_b_d;
   logic [WIDTH-1:0] exp_q [0:LATENCY];
   logic             vld_q [0:LATENCY];
   logic [WIDTH-1:0] data_q, data_d, event_q, event_d, debug_q, debug_d;
   logic [WIDTH-1:0] data_out_q, data_out_d, event_out_q, event_out_d;
   logic             sticky_q, sticky_d, cmp, mis;

   // The compare stage is the last pipeline slot; with LATENCY=0 that is stage 0,
   // checked one edge after the drive registers load.
   always_comb begin
      cmp         = vld_q[LATENCY];
      mis         = cmp && (i_dut_out != exp_q[LATENCY]);
      lfsr_a_d    = enable ? lfsr_step(lfsr_a_q) : lfsr_a_q;
      lfsr_b_d    = enable ? lfsr_step(lfsr_b_q) : lfsr_b_q;
      drive_a_d   = enable ? lfsr_a_q[WIDTH-1:0] : drive_a_q;
      drive_b_d   = enable ? lfsr_b_q[WIDTH-1:0] : drive_b_q;
      data_d      = (cmp && data_q != '1) ? data_q + ONE : data_q;
      event_d     = (mis && event_q != '1) ? event_q + ONE : event_q;
      debug_d     = (mis && !sticky_q) ? i_dut_out : debug_q;
      sticky_d    = sticky_q | mis;
      data_out_d  = freeze ? data_out_q : data_q;
      event_out_d = freeze ? event_out_q : event_q;
   end

   always_ff @(posedge clk_dut) begin
      if (reset) begin
         lfsr_a_q    <= SEED_A;
         lfsr_b_q    <= SEED_B;
         drive_a_q   <= '0;
         drive_b_q   <= '0;
         data_q      <= '0;
         event_q     <= '0;
         debug_q     <= '0;
         sticky_q    <= 1'b0;
         data_out_q  <= '0;
         event_out_q <= '0;
         for (int i = 0; i <= LATENCY; i++) begin
            exp_q[i] <= '0;
            vld_q[i] <= 1'b0;
         end
      end else begin
         lfsr_a_q    <= lfsr_a_d;
         lfsr_b_q    <= lfsr_b_d;
         drive_a_q   <= drive_a_d;
         drive_b_q   <= drive_b_d;
         data_q      <= data_d;
         event_q     <= event_d;
         debug_q     <= debug_d;
         sticky_q    <= sticky_d;
         data_out_q  <= data_out_d;
         event_out_q <= event_out_d;
         vld_q[0]    <= enable;
         exp_q[0]    <= enable ? lfsr_a_q[WIDTH-1:0] + lfsr_b_q[WIDTH-1:0] : exp_q[0];
         for (int i = 1; i <= LATENCY; i++) begin
            exp_q[i] <= exp_q[i-1];
            vld_q[i] <= vld_q[i-1];
         end
      end
   end

   assign o_drive_a   = drive_a_q;
   assign o_drive_b   = drive_b_q;
   assign o_data_ctr  = data_out_q;
   assign o_event_ctr = event_out_q;
   assign o_debug     = debug_q;
endmodule

// File: doc/arith_stim_checker.md
Name: arith_stim_checker

Overview:
- Stimulus and checker stage inside the arithmetic test harness.
- Generates pseudo-random operand pairs and drives them to the DUT adder.
- Captures the DUT sum LATENCY cycles later and compares it against an internally computed expected sum.
- Accumulates sample and mismatch counters that the host reads through the Avalon-mapped control wrapper.

Parameters:
- WIDTH, 32, operand/sum/counter width; legal range 8..32.
- LATENCY, 2, DUT pipeline depth in clk_dut cycles; legal range 0..15.
- SEED_A, 32'h00000001, LFSR A reset value; must be non-zero.
- SEED_B, 32'h0000ACE1, LFSR B reset value; must be non-zero.

Ports:
- clk_dut  input  1  single clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = issue one new operand pair per cycle.
- freeze  input  1  1 = hold counter outputs at their current snapshot.
- o_drive_a  output  WIDTH  operand A to DUT.
- o_drive_b  output  WIDTH  operand B to DUT.
- i_dut_out  input  WIDTH  DUT sum.
- o_data_ctr  output  WIDTH  samples compared.
- o_event_ctr  output  WIDTH  mismatches detected.
- o_debug  output  WIDTH  first mismatching DUT value; sticky.

Behaviour:
- Reset (sync, highest priority):
  - lfsr_a<=SEED_A, lfsr_b<=SEED_B.
  - o_drive_a/b, o_data_ctr, o_event_ctr, o_debug <= 0.
  - Valid and expected pipelines cleared; internal counters and the sticky flag cleared.
  - Samples in flight at reset are discarded and never counted.
- LFSRs: 32-bit Galois, mask 32'h80200003, shift right (lsb out; if lsb=1, XOR mask). Operands are the LFSR bits [WIDTH-1:0].
- enable=1 cycle:
  - o_drive_a<=lfsr_a[WIDTH-1:0] and o_drive_b<=lfsr_b[WIDTH-1:0].
  - Both LFSRs step.
  - Expected stage 0 <= (lfsr_a+lfsr_b) mod 2^WIDTH, with the carry dropped.
  - Valid stage 0 <= 1.
- enable=0 cycle:
  - LFSRs and drives hold.
  - Valid stage 0 <= 0.
  - Pipelines keep shifting, so in-flight samples still drain and are checked.
- Alignment:
  - Stage 0 is loaded on the same edge as the drive registers.
  - Stages 1..LATENCY shift every cycle.
  - At each edge where valid stage LATENCY = 1, i_dut_out is compared with expected stage LATENCY.
  - LATENCY=0 means the DUT is combinational: the compare uses stage 0 on the edge after the drive.
- Counters:
  - Internal data count +1 per compared sample; event count +1 per compare with inequality.
  - Both saturate at all-ones; no wrap.
- o_debug: on the first mismatch since reset, o_debug<=i_dut_out and a sticky flag is set. Later mismatches do not update it.
- Freeze:
  - When freeze=0, o_data_ctr/o_event_ctr <= internal counts each edge, giving one cycle of lag.
  - When freeze=1, the outputs hold. Internal counting continues regardless.
  - On freeze release, the outputs show the live counts after 1 edge.
- Simultaneous events: reset overrides enable and freeze. A compare and enable in the same cycle are independent. Toggling enable never drops or duplicates a sample.

Test Plan:
- First pair: reset, then enable=1 for one cycle.
  - Next cycle: o_drive_a=32'h00000001, o_drive_b=32'h0000ACE1.
  - Ideal adder, LATENCY=2: o_data_ctr=1 and o_event_ctr=0 five edges after enable.
- Clean run: ideal adder model, LATENCY=2, enable for 100 cycles, then 0.
  - After a drain of 4 cycles: o_data_ctr=100, o_event_ctr=0, o_debug=0.
- Single fault: the model inverts bit0 of the 10th sum (value S10).
  - Result: o_event_ctr=1, o_debug=S10^1, o_data_ctr=100. A second injected fault at sample 20 gives event=2 with o_debug unchanged.
- Freeze: assert freeze when o_data_ctr=50, run 30 more samples.
  - While frozen: the output stays at 50.
  - After release: 80 on the next edge.
- Reset mid-run: assert reset with 2 samples in flight.
  - Next edge: all outputs are 0.
  - Restart: the first drive equals SEED_A again and the in-flight samples are never counted.
- Saturation and edge latency: WIDTH=8, LATENCY=0, 300 samples, every 3rd corrupted.
  - Result: o_data_ctr=255, o_event_ctr=100.
  - LATENCY=15 clean run of 20 samples gives 20/0.
